pipe_regfile: RTL
=================

// Module: pipe_regfile
// PURPOSE
//  Parametrised multi-read, single-write register file for the pipelined CPU core.
//  Generalises the 32x32 2R1W single-cycle file to N read ports, any width and depth.
//  Adds a pending-write scoreboard for hazard detection and a sequential clear-sweep FSM.
//  Sits between decode (reads, claims) and writeback (writes).
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W
//  NUM_RD    2   number of combinational read ports (1..4)
//  ZERO_REG  1   1: register 0 is hardwired to zero, never written, never pending
// PORTS
//  clk         in   1               clock, rising edge
//  reset       in   1               asynchronous, active-high
//  rd_addr     in   NUM_RD*ADDR_W   read addresses; port k = bits [k*ADDR_W +: ADDR_W]
//  rd_data     out  NUM_RD*DATA_W   read data, packed the same way
//  rd_pend     out  NUM_RD          1 = addressed register has an outstanding producer
//  we          in   1               write enable (writeback)
//  wr_addr     in   ADDR_W          write address
//  wr_data     in   DATA_W          write data
//  claim_en    in   1               decode issues an instruction that will write claim_addr
//  claim_addr  in   ADDR_W          destination register being claimed
//  clr_req     in   1               start a clear sweep (one-cycle pulse)
//  clr_busy    out  1               clear sweep in progress
// BEHAVIOUR
//  Reset (async): all registers = 0; all pending bits = 0; FSM = IDLE; clr_busy = 0.
//  Reads: combinational, zero latency. With ZERO_REG=1, address 0 returns 0 and rd_pend = 0.
//  Write: on posedge clk when we=1 and state=IDLE; dropped if ZERO_REG=1 and wr_addr=0.
//  Scoreboard: one pending bit per register.
//   - claim_en=1 sets pend[claim_addr]; a valid write clears pend[wr_addr].
//   - Claim and write to the same address in one cycle: the claim wins and pend stays 1.
//   - Register 0 is never set when ZERO_REG=1. Claims while in CLEAR are ignored.
//  FSM: IDLE, CLEAR.
//   - IDLE -> CLEAR on clr_req: all pending bits cleared, sweep counter = ZERO_REG ? 1 : 0.
//   - CLEAR: zero reg[cnt] each cycle, cnt++; clr_busy = 1; we and claim_en are ignored.
//   - CLEAR -> IDLE after cnt = DEPTH-1 is zeroed. The counter does not wrap.
//   - Sweep takes DEPTH-ZERO_REG cycles.
//   - clr_req during CLEAR is ignored.
//   - Reads during CLEAR return the current array contents.
//  Reset mid-sweep: immediate return to the reset state; the sweep is abandoned.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: write-through forwarding.
//   - A read port whose address matches a valid same-cycle write returns wr_data.
//   - That port's rd_pend = 0, unless a same-cycle claim targets that address.
//  Not defined: reads return the stored value; new data is visible the cycle after the write.
// STRUCTURE
//  Package regfile_pkg: default DATA_W/ADDR_W constants, fsm_state_t enum {IDLE, CLEAR}.
//  Sub-module regfile_scoreboard: DEPTH-bit pending vector with claim/clear/flush inputs.
//   - Instantiated once; read lookups are done in the parent.
// TESTING
//  1 Reset, then write r5=0xDEADBEEF; next cycle read r5 on both ports -> 0xDEADBEEF, r0 -> 0.
//  2 Write r0=0x1234 (ZERO_REG=1) -> r0 still reads 0; claim r0 -> rd_pend stays 0.
//  3 Claim r7; cycle 3 write r7 -> rd_pend(r7)=1 over cycles 1-3, 0 from cycle 4.
//    Claim+write r7 in the same cycle -> stays 1.
//  4 Fill r1..r31 with nonzero, pulse clr_req -> clr_busy high exactly 31 cycles, all read 0.
//    A write issued during the sweep is dropped.
//  5 Async reset asserted at sweep cycle 10 -> clr_busy=0 immediately, all regs 0, FSM IDLE.
//  6 BYPASS_EN: same-cycle write r9=0xA5A5A5A5 and read r9 -> rd_data=0xA5A5A5A5, rd_pend=0.
//    Without BYPASS_EN -> old value that cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and FSM state type for the pipelined register file
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-write scoreboard, one bit per register
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_set_en,
    input  logic [ADDR_W-1:0]        i_set_addr,
    input  logic                     i_clr_en,
    input  logic [ADDR_W-1:0]        i_clr_addr,
    input  logic                     i_flush,
    output logic [(1<<ADDR_W)-1:0]   o_pend
);

    logic [(1<<ADDR_W)-1:0] r_pend;
    logic [(1<<ADDR_W)-1:0] w_pend_next;

    // Clear before set so a same-cycle claim keeps the register pending.
    always_comb begin
        w_pend_next = r_pend;
        if (i_flush) begin
            w_pend_next = '0;
        end else begin
            if (i_clr_en)
                w_pend_next[i_clr_addr] = 1'b0;
            if (i_set_en)
                w_pend_next[i_set_addr] = 1'b1;
        end
        if (ZERO_REG != 0)
            w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_pend <= '0;
        else
            r_pend <= w_pend_next;
    end

    assign o_pend = r_pend;

endmodule

// File: rtl/pipe_regfile.sv
// rtl/pipe_regfile.sv - N-read 1-write register file with scoreboard and clear sweep; REGFILE_BYPASS_EN enables write-through forwarding
module pipe_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_pend,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_claim_en,
    input  logic [ADDR_W-1:0]        i_claim_addr,
    input  logic                     i_clr_req,
    output logic                     o_clr_busy
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam bit              ZR        = (ZERO_REG != 0);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ZR ? ADDR_W'(1) : '0;

    fsm_state_t        r_state;
    fsm_state_t        w_state_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_idle;
    logic              w_wr_valid;
    logic              w_claim_valid;
    logic              w_flush;
    logic [DEPTH-1:0]  w_pend;

    assign w_idle        = (r_state == IDLE);
    assign w_wr_valid    = i_we && w_idle && !(ZR && (i_wr_addr == '0));
    assign w_claim_valid = i_claim_en && w_idle && !(ZR && (i_claim_addr == '0));
    assign w_flush       = w_idle && i_clr_req;
    assign o_clr_busy    = (r_state == CLEAR);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_clr_req) w_state_next = CLEAR;
            CLEAR:   if (r_cnt == LAST_IDX) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Sweep index parks on the last entry rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (w_flush)
            r_cnt <= FIRST_IDX;
        else if (!w_idle && (r_cnt != LAST_IDX))
            r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (o_clr_busy) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_valid) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .i_set_en   (w_claim_valid),
        .i_set_addr (i_claim_addr),
        .i_clr_en   (w_wr_valid),
        .i_clr_addr (i_wr_addr),
        .i_flush    (w_flush),
        .o_pend     (w_pend)
    );

    genvar g;
    for (g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_data;
        logic              w_pnd;

        assign w_ra = i_rd_addr[g*ADDR_W +: ADDR_W];

        always_comb begin
            w_data = '0;
            w_pnd  = 1'b0;
            if (ZR && (w_ra == '0)) begin
                w_data = '0;
                w_pnd  = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            else if (w_wr_valid && (i_wr_addr == w_ra)) begin
                w_data = i_wr_data;
                w_pnd  = w_claim_valid && (i_claim_addr == w_ra);
            end
`endif
            else begin
                w_data = r_mem[w_ra];
                w_pnd  = w_pend[w_ra];
            end
        end

        assign o_rd_data[g*DATA_W +: DATA_W] = w_data;
        assign o_rd_pend[g]                  = w_pnd;
    end

endmodule
